// File: rtl/attn_score_softmax_engine.sv
// Streaming attention-score engine.
// Accumulates DIM-length signed q.k dot products one feature pair per beat,
// scales each score and maps it through a fixed-point exp2-based e^x
// approximation. Every exp value is emitted on a valid/ready output; after
// NKEYS exp beats one extra beat carries the row's softmax denominator.
module attn_score_softmax_engine #(
    parameter int W           = 8,  // signed input width, Q0.(W-1)
    parameter int DIM         = 4,  // features per dot product (>= 2)
    parameter int NKEYS       = 8,  // scores per row before the sum beat (>= 2)
    parameter int SCALE_SHIFT = 1,  // score scaling, approx. 1/sqrt(DIM)
    parameter int OUT_W       = 9   // exp output width, UQ(OUT_W-6).6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [W-1:0]                     in_q,
    input  logic [W-1:0]                     in_k,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OUT_W+$clog2(NKEYS)-1:0]   out_data,
    output logic                             out_is_sum
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int ACC_W  = 2 * W + $clog2(DIM);       // signed dot-product accumulator
    localparam int SUM_W  = OUT_W + $clog2(NKEYS);     // holds NKEYS saturated exps
    localparam int FW     = $clog2(DIM);
    localparam int KW     = $clog2(NKEYS);
    localparam int XSHIFT = 2 * W - 8 + SCALE_SHIFT;   // product is Q.(2W-2); land on Q.6
    localparam int PW     = ACC_W + 9;                 // room for x6 * 185
    localparam int SAW    = $clog2(OUT_W);             // left-shift amount width

    localparam logic signed [PW-1:0] LOG2E_Q7 = PW'(185);       // log2(e) in Q.7
    localparam logic signed [PW-1:0] I_SAT    = PW'(OUT_W - 6); // mant<<i no longer fits
    localparam logic signed [PW-1:0] I_UFLOW  = PW'(-7);        // mant>>7 is always zero
    localparam logic [OUT_W-1:0]     E_MAX    = '1;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_EXP,
        ST_SUM
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                    state_q,      state_d;
    logic signed [ACC_W-1:0]   acc_q,        acc_d;
    logic [FW-1:0]             feat_cnt_q,   feat_cnt_d;
    logic [KW-1:0]             key_cnt_q,    key_cnt_d;
    logic [SUM_W-1:0]          sum_q,        sum_d;
    logic                      out_valid_q,  out_valid_d;
    logic [SUM_W-1:0]          out_data_q,   out_data_d;
    logic                      out_is_sum_q, out_is_sum_d;

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic signed [2*W-1:0]     prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [PW-1:0]      x6;
    logic signed [PW-1:0]      y6;
    logic signed [PW-1:0]      exp_i;
    logic [5:0]                frac;
    logic [6:0]                mant;
    logic [2:0]                rshift;
    logic [OUT_W-1:0]          e_val;
    logic                      slot_free;

    // Signed feature product, sign-extended to the accumulator width.
    always_comb begin
        prod     = $signed(in_q) * $signed(in_k);
        prod_ext = ACC_W'(prod);
        acc_base = (feat_cnt_q == '0) ? '0 : acc_q;
    end

    // e^x approximation from the finished dot product, floor semantics:
    // e^x = 2^(x*log2 e); integer part shifts the mantissa 1.f (Q.6).
    always_comb begin
        x6     = PW'(acc_q) >>> XSHIFT;
        y6     = (x6 * LOG2E_Q7) >>> 7;
        exp_i  = y6 >>> 6;
        frac   = y6[5:0];
        mant   = {1'b1, frac};
        rshift = 3'd0 - exp_i[2:0];
        if (!exp_i[PW-1]) begin
            if (exp_i >= I_SAT) begin
                e_val = E_MAX;
            end else begin
                e_val = OUT_W'(mant) << exp_i[SAW-1:0];
            end
        end else if (exp_i <= I_UFLOW) begin
            e_val = '0;
        end else begin
            e_val = OUT_W'(mant >> rshift);
        end
    end

    // Next-state logic for the ACCUM -> EXP -> (SUM) sequence and output slot.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d      = state_q;
        acc_d        = acc_q;
        feat_cnt_d   = feat_cnt_q;
        key_cnt_d    = key_cnt_q;
        sum_d        = sum_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_is_sum_d = out_is_sum_q;

        slot_free = !out_valid_q || out_ready;

        // An accepted beat empties the slot unless a new load follows below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    acc_d = acc_base + prod_ext;
                    if (feat_cnt_q == FW'(DIM - 1)) begin
                        feat_cnt_d = '0;
                        state_d    = ST_EXP;
                    end else begin
                        feat_cnt_d = feat_cnt_q + 1'b1;
                    end
                end
            end

            ST_EXP: begin
                if (slot_free) begin
                    out_data_d   = SUM_W'(e_val);
                    out_is_sum_d = 1'b0;
                    out_valid_d  = 1'b1;
                    sum_d        = sum_q + SUM_W'(e_val);
                    key_cnt_d    = key_cnt_q + 1'b1;
                    state_d      = (key_cnt_q == KW'(NKEYS - 1)) ? ST_SUM : ST_ACCUM;
                end
            end

            ST_SUM: begin
                if (slot_free) begin
                    out_data_d   = sum_q;
                    out_is_sum_d = 1'b1;
                    out_valid_d  = 1'b1;
                    sum_d        = '0;
                    key_cnt_d    = '0;
                    state_d      = ST_ACCUM;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State register with synchronous active-low reset; drops any partial row.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q      <= ST_ACCUM;
            acc_q        <= '0;
            feat_cnt_q   <= '0;
            key_cnt_q    <= '0;
            sum_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_is_sum_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            feat_cnt_q   <= feat_cnt_d;
            key_cnt_q    <= key_cnt_d;
            sum_q        <= sum_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_is_sum_q <= out_is_sum_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_is_sum = out_is_sum_q;

endmodule
